// File: rtl/load_scoreboard_stall.sv
// Load scoreboard: in-order FIFO of outstanding load destinations, raising a
// decode stall on read-after-load hazards or when the FIFO cannot accept a load.
module load_scoreboard_stall #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 3,
    parameter bit          RESP_BYPASS = 1'b1
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_ex_ls_valid,
    input  logic              I_ex_ls_load,
    input  logic              I_ex_fire,
    input  logic [REG_AW-1:0] I_ex_rd_waddr,
    input  logic              I_dec_rs1_re,
    input  logic              I_dec_rs2_re,
    input  logic [REG_AW-1:0] I_dec_rs1_raddr,
    input  logic [REG_AW-1:0] I_dec_rs2_raddr,
    input  logic              I_bru_taken,
    input  logic              I_lsu_resp_valid,
    output logic              O_stallreq,
    output logic              O_full,
    output logic [CNT_W-1:0]  O_pending_cnt,
    output logic              O_underflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [REG_AW-1:0] rd_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              underflow_q, underflow_d;

    logic              ex_load, empty, enq, deq;
    logic [DEPTH-1:0]  cmp_mask;
    logic              rs1_nz, rs2_nz, rs1_ex, rs2_ex, rs1_fifo, rs2_fifo;
    logic              ex_stall, fifo_stall;

    assign ex_load = I_ex_ls_valid & I_ex_ls_load;
    assign empty   = (count_q == '0);
    assign deq     = I_lsu_resp_valid & ~empty;
    // A full FIFO still takes a load when the head retires in the same cycle
    assign enq     = I_ex_fire & ex_load & ~I_bru_taken & (~full_q | I_lsu_resp_valid);

    // Next-state for the FIFO, count and sticky underflow
    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        underflow_d = underflow_q | (I_lsu_resp_valid & empty);
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            rd_d[tail_q]    = I_ex_rd_waddr;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            full_q      <= full_d;
            underflow_q <= underflow_d;
        end
    end

    // Retiring head is invisible to hazard compares when bypass is enabled
    always_comb begin
        cmp_mask = valid_q;
        if (RESP_BYPASS && deq) begin
            cmp_mask[head_q] = 1'b0;
        end
    end

    always_comb begin
        rs1_fifo = 1'b0;
        rs2_fifo = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (cmp_mask[i] && (rd_q[i] == I_dec_rs1_raddr)) begin
                rs1_fifo = 1'b1;
            end
            if (cmp_mask[i] && (rd_q[i] == I_dec_rs2_raddr)) begin
                rs2_fifo = 1'b1;
            end
        end
    end

    assign rs1_nz = (I_dec_rs1_raddr != '0);
    assign rs2_nz = (I_dec_rs2_raddr != '0);
    assign rs1_ex = ex_load & (I_ex_rd_waddr == I_dec_rs1_raddr);
    assign rs2_ex = ex_load & (I_ex_rd_waddr == I_dec_rs2_raddr);

    // EX-load hits stay live in reset; FIFO-derived stalls are gated by it
    assign ex_stall   = (I_dec_rs1_re & rs1_nz & rs1_ex) | (I_dec_rs2_re & rs2_nz & rs2_ex);
    assign fifo_stall = I_rst_n & ((I_dec_rs1_re & rs1_nz & rs1_fifo)
                                 | (I_dec_rs2_re & rs2_nz & rs2_fifo)
                                 | (ex_load & full_q & ~I_lsu_resp_valid));

    assign O_stallreq    = ~I_bru_taken & (ex_stall | fifo_stall);
    assign O_full        = full_q;
    assign O_pending_cnt = count_q;
    assign O_underflow   = underflow_q;

endmodule

// File: tb/tb_load_scoreboard_stall.sv
// Bench for load_scoreboard_stall: directed scenarios plus random traffic,
// checked against a queue-based model for both bypass settings.
module tb_load_scoreboard_stall;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          exv, exl, fire, bru, resp, re1, re2;
    logic [AW-1:0] ex_rd, rs1, rs2;

    logic          stall_b, full_b, uf_b;
    logic [CW-1:0] cnt_b;
    logic          stall_n, full_n, uf_n;
    logic [CW-1:0] cnt_n;

    int            ncmp  = 0;
    int            nfail = 0;

    logic [AW-1:0] q[$];
    bit            uf;

    always #5 clk = ~clk;

    load_scoreboard_stall #(.REG_AW(AW), .DEPTH(DEPTH), .CNT_W(CW), .RESP_BYPASS(1'b1)) u_dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_ex_ls_valid(exv), .I_ex_ls_load(exl), .I_ex_fire(fire), .I_ex_rd_waddr(ex_rd),
        .I_dec_rs1_re(re1), .I_dec_rs2_re(re2), .I_dec_rs1_raddr(rs1), .I_dec_rs2_raddr(rs2),
        .I_bru_taken(bru), .I_lsu_resp_valid(resp),
        .O_stallreq(stall_b), .O_full(full_b), .O_pending_cnt(cnt_b), .O_underflow(uf_b)
    );

    load_scoreboard_stall #(.REG_AW(AW), .DEPTH(DEPTH), .CNT_W(CW), .RESP_BYPASS(1'b0)) u_dut_nb (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_ex_ls_valid(exv), .I_ex_ls_load(exl), .I_ex_fire(fire), .I_ex_rd_waddr(ex_rd),
        .I_dec_rs1_re(re1), .I_dec_rs2_re(re2), .I_dec_rs1_raddr(rs1), .I_dec_rs2_raddr(rs2),
        .I_bru_taken(bru), .I_lsu_resp_valid(resp),
        .O_stallreq(stall_n), .O_full(full_n), .O_pending_cnt(cnt_n), .O_underflow(uf_n)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Does register rs depend on a load still in flight (EX or queued)?
    function automatic bit m_hit(input logic [AW-1:0] rs, input bit byp, input bit retiring);
        if (rs == '0) return 1'b0;
        if (exv && exl && ex_rd == rs) return 1'b1;
        if (!rst_n) return 1'b0;
        foreach (q[i]) begin
            if (q[i] == rs && !(byp && retiring && i == 0)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_stall(input bit byp);
        bit retiring;
        bit no_room;
        retiring = resp && (q.size() != 0);
        no_room  = rst_n && exv && exl && (q.size() == DEPTH) && !resp;
        return !bru && ((re1 && m_hit(rs1, byp, retiring)) ||
                        (re2 && m_hit(rs2, byp, retiring)) || no_room);
    endfunction

    // Check all outputs mid-cycle, then advance one clock and the model with it
    task automatic cyc(input string tag);
        bit deq, enq;
        int sz;
        #2;
        if (!rst_n) begin
            q.delete();
            uf = 1'b0;
        end
        sz = q.size();
        chk({tag, ":cnt"},    8'(cnt_b),   8'(sz));
        chk({tag, ":cnt_nb"}, 8'(cnt_n),   8'(sz));
        chk({tag, ":full"},   8'(full_b),  8'(sz == DEPTH));
        chk({tag, ":full_nb"},8'(full_n),  8'(sz == DEPTH));
        chk({tag, ":uf"},     8'(uf_b),    8'(uf));
        chk({tag, ":uf_nb"},  8'(uf_n),    8'(uf));
        chk({tag, ":stall"},  8'(stall_b), 8'(m_stall(1'b1)));
        chk({tag, ":stall_nb"},8'(stall_n),8'(m_stall(1'b0)));
        deq = rst_n && resp && sz != 0;
        enq = rst_n && fire && exv && exl && !bru && (sz < DEPTH || resp);
        if (rst_n && resp && sz == 0) uf = 1'b1;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (enq) q.push_back(ex_rd);
        #1;
    endtask

    task automatic idle();
        exv = 0; exl = 0; fire = 0; bru = 0; resp = 0; re1 = 0; re2 = 0;
        ex_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic ex_load(input logic f, input logic [AW-1:0] rd);
        exv = 1; exl = 1; fire = f; ex_rd = rd;
    endtask

    initial begin
        idle();
        uf    = 1'b0;
        rst_n = 1'b0;
        #1;
        cyc("reset");
        cyc("reset2");
        rst_n = 1'b1;
        cyc("idle");

        // Load to x5 followed by three dependent decode reads, response in the third
        ex_load(1, 5'd5);               cyc("x5_fire");
        idle(); re1 = 1; rs1 = 5'd5;    cyc("x5_c1");
        cyc("x5_c2");
        resp = 1;                       cyc("x5_c3");
        resp = 0;                       cyc("x5_c4");
        idle();                         cyc("x5_done");

        // Fill to DEPTH, then a fifth load in EX, then refill on a response
        for (int i = 1; i <= 4; i++) begin
            ex_load(1, AW'(i));         cyc("fill");
        end
        ex_load(0, 5'd6);               cyc("fifth_wait");
        fire = 1; resp = 1;             cyc("fifth_swap");
        idle(); re2 = 1; rs2 = 5'd1;    cyc("x1_gone");
        rs2 = 5'd6;                     cyc("x6_pend");
        idle();
        for (int i = 0; i < 4; i++) begin
            resp = 1;                   cyc("drain");
        end
        idle();                         cyc("drained");

        // Branch redirect kills the EX load and its stall
        ex_load(1, 5'd7); re2 = 1; rs2 = 5'd7; bru = 1; cyc("bru_kill");
        idle();                         cyc("bru_after");

        // Load to x0 is queued but never hazards
        ex_load(1, 5'd0); re1 = 1; rs1 = 5'd0; cyc("x0_fire");
        idle(); re1 = 1; rs1 = 5'd0;    cyc("x0_read");
        resp = 1;                       cyc("x0_pop");
        idle();                         cyc("x0_empty");

        // Response while empty sets the sticky underflow
        resp = 1;                       cyc("uf_set");
        idle();                         cyc("uf_hold");

        // Asynchronous reset with three loads in flight
        for (int i = 0; i < 3; i++) begin
            ex_load(1, AW'(i + 9));     cyc("pre_rst");
        end
        idle(); re1 = 1; rs1 = 5'd10;   cyc("pend10");
        rst_n = 1'b0;                   cyc("async_rst");
        rst_n = 1'b1;                   cyc("post_rst");
        resp = 1;                       cyc("post_rst_resp");
        idle();                         cyc("post_rst_uf");

        // Random traffic with small register numbers to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            exv   = $urandom_range(0, 3) != 0;
            exl   = $urandom_range(0, 3) != 0;
            fire  = $urandom_range(0, 1);
            bru   = $urandom_range(0, 9) == 0;
            resp  = $urandom_range(0, 2) == 0;
            re1   = $urandom_range(0, 1);
            re2   = $urandom_range(0, 1);
            ex_rd = AW'($urandom_range(0, 7));
            rs1   = AW'($urandom_range(0, 7));
            rs2   = AW'($urandom_range(0, 7));
            cyc("rand");
        end
        rst_n = 1'b1;
        idle();
        cyc("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
